sent_rx_pulse_decode: RTL and testbench
=======================================

SENT_RX_PULSE_DECODE -- requirements
Module: sent_rx_pulse_decode

Interface
REQ-001 Parameter NUM_DATA, default 6: data nibbles per fast-channel frame, excluding the status and CRC nibbles.
REQ-002 Parameter SYNC_TOL, default 1: accepted deviation from 56 ticks for a sync period, in ticks.
REQ-003 clk  input  1  the single clock; every register is clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ticks  input  1  one-clk strobe per SENT unit time.
REQ-006 enable  input  1  high = decoding enabled; low = FSM held in IDLE.
REQ-007 optional_pause  input  1  high = a pause period follows each CRC nibble.
REQ-008 data_pulse  input  1  SENT line, asynchronous to clk.
REQ-009 nibble_valid  output  1  one-clk strobe: nibble_data and nibble_idx are valid.
REQ-010 nibble_data  output  4  decoded nibble value.
REQ-011 nibble_idx  output  4  0 = status, 1..NUM_DATA = data, NUM_DATA+1 = CRC.
REQ-012 sync_valid  output  1  one-clk strobe: valid sync period accepted.
REQ-013 frame_done  output  1  one-clk strobe, asserted with the CRC nibble_valid.
REQ-014 err  output  1  one-clk strobe: protocol error.
REQ-015 err_code  output  2  0 bad nibble, 1 bad sync, 2 bad pause, 3 timeout; held until the next err.

Function
REQ-016 data_pulse SHALL pass through a 2-flop synchronizer; a falling edge is detected on synchronized 1 -> 0 and is called an "edge".
REQ-017 Tick counter SHALL be 10-bit and saturate at 1023; on the edge cycle, period = cnt + ticks, then cnt <= 0.
REQ-018 All outputs SHALL be registered and asserted the clk after the edge cycle, i.e. 4 clk after the pin edge.
REQ-019 FSM states SHALL be IDLE, HUNT, NIBBLES, PAUSE and WAIT_SYNC.
REQ-020 IDLE: on edge (with enable high), clear cnt and go to HUNT; no output is asserted.
REQ-021 HUNT: on an edge with period within 56±SYNC_TOL, pulse sync_valid, set nibble_idx to 0 and go to NIBBLES; on any other edge, stay in HUNT silently.
REQ-022 NIBBLES: on an edge with period 12..27, pulse nibble_valid with nibble_data = period-12, then increment nibble_idx.
REQ-023 When the CRC nibble is accepted, SHALL pulse frame_done and go to PAUSE if optional_pause is high, else to WAIT_SYNC.
REQ-024 NIBBLES: on an edge with period outside 12..27, SHALL raise err with code 0 and go to HUNT.
REQ-025 PAUSE: on an edge with period 12..768, go to WAIT_SYNC; otherwise raise err with code 2 and go to HUNT.
REQ-026 WAIT_SYNC: on an edge with period in the sync window, pulse sync_valid and go to NIBBLES with nibble_idx 0; otherwise raise err with code 1 and go to HUNT.
REQ-027 Timeout: if cnt reaches 1023 in any state other than IDLE, SHALL raise err with code 3 and go to IDLE.
REQ-028 optional_pause SHALL be sampled on the CRC edge cycle only.
REQ-029 enable low SHALL force IDLE on the next clk and suppress all strobes; in-progress frame data is discarded.
REQ-030 At most one of sync_valid, nibble_valid and err SHALL be asserted in any cycle.

Reset
REQ-031 When reset is high at a clk edge, all registers SHALL clear on that edge.
REQ-032 After reset, the state SHALL be IDLE and cnt 0.
REQ-033 After reset, every output SHALL be 0, and the synchronizer flops SHALL be 1 (line idle high).
REQ-034 Reset asserted mid-frame SHALL discard the frame, with no frame_done or err emitted.

Structure
REQ-035 Package sent_pkg SHALL hold the state enum, SYNC_TICKS=56, NIBBLE_BASE=12, NIBBLE_MAX=27, PAUSE_MIN=12, PAUSE_MAX=768, CNT_MAX=1023, and the err_code constants.
REQ-036 The synchronizer and edge detector SHALL be sub-module sent_rx_edge_detect; the counter and FSM stay in the top.

Verification
REQ-037 Case 1: optional_pause=0; sync 56, nibbles 12+{5,1,2,3,4,5,6,9} -> sync_valid, then 8 nibble_valid with data 5,1,2,3,4,5,6,9 and idx 0..7, then frame_done together with idx 7.
REQ-038 Case 2: optional_pause=1; frame followed by a 100-tick pause, then sync 57 -> no err, second sync_valid asserted.
REQ-039 Case 3: sync 56, then a 30-tick nibble -> err with code 0, state HUNT; next 55-tick sync is accepted.
REQ-040 Case 4: optional_pause=0; after CRC, the next period is 40 ticks -> err with code 1; an 800-tick pause with optional_pause=1 -> err with code 2.
REQ-041 Case 5: line held high for 1100 ticks after a sync -> err with code 3, state IDLE.
REQ-042 Case 6: reset pulsed after nibble 3, or enable dropped mid-frame -> no strobes; the next full frame decodes correctly.

Source files
------------

// File: rtl/sent_rx_pulse_decode_pkg.sv
// Shared SENT receiver constants, FSM state encoding and period-window helper.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_NIBBLES,
        ST_PAUSE,
        ST_WAIT_SYNC
    } state_e;

    localparam int SYNC_TICKS  = 56;
    localparam int NIBBLE_BASE = 12;
    localparam int NIBBLE_MAX  = 27;
    localparam int PAUSE_MIN   = 12;
    localparam int PAUSE_MAX   = 768;
    localparam int CNT_MAX     = 1023;

    localparam logic [1:0] ERR_NIBBLE  = 2'd0;
    localparam logic [1:0] ERR_SYNC    = 2'd1;
    localparam logic [1:0] ERR_PAUSE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic logic in_window(input logic [10:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/sent_rx_edge_detect.sv
// Two-flop synchronizer for the SENT line plus a registered falling-edge strobe.
module sent_rx_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic data_pulse,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic fall_q, fall_d;

    always_comb begin
        meta_d = data_pulse;
        sync_d = meta_q;
        prev_d = sync_q;
        fall_d = prev_q & ~sync_q;
    end

    // Idle SENT line is high, so the history flops reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/sent_rx_pulse_decode.sv
// SENT fast-channel receiver: measures falling-edge periods in ticks and decodes
// sync, status/data/CRC nibbles and the optional pause into registered strobes.
module sent_rx_pulse_decode
    import sent_pkg::*;
#(
    parameter int NUM_DATA = 6,
    parameter int SYNC_TOL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ticks,
    input  logic       enable,
    input  logic       optional_pause,
    input  logic       data_pulse,
    output logic       nibble_valid,
    output logic [3:0] nibble_data,
    output logic [3:0] nibble_idx,
    output logic       sync_valid,
    output logic       frame_done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam logic [3:0] CRC_IDX = 4'(NUM_DATA + 1);

    logic fall;

    sent_rx_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .data_pulse (data_pulse),
        .fall       (fall)
    );

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [3:0] nib_cnt_q, nib_cnt_d;
    logic       nibble_valid_q, nibble_valid_d;
    logic [3:0] nibble_data_q, nibble_data_d;
    logic [3:0] nibble_idx_q, nibble_idx_d;
    logic       sync_valid_q, sync_valid_d;
    logic       frame_done_q, frame_done_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;

    // The tick arriving on the edge cycle belongs to the period that just ended.
    logic [10:0] period;
    logic        sync_ok, nib_ok, pause_ok;

    assign period   = {1'b0, cnt_q} + {10'd0, ticks};
    assign sync_ok  = in_window(period, SYNC_TICKS - SYNC_TOL, SYNC_TICKS + SYNC_TOL);
    assign nib_ok   = in_window(period, NIBBLE_BASE, NIBBLE_MAX);
    assign pause_ok = in_window(period, PAUSE_MIN, PAUSE_MAX);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        nib_cnt_d      = nib_cnt_q;
        nibble_valid_d = 1'b0;
        sync_valid_d   = 1'b0;
        frame_done_d   = 1'b0;
        err_d          = 1'b0;
        nibble_data_d  = nibble_data_q;
        nibble_idx_d   = nibble_idx_q;
        err_code_d     = err_code_q;

        if (fall)
            cnt_d = '0;
        else if (ticks && cnt_q != 10'(CNT_MAX))
            cnt_d = cnt_q + 10'd1;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q != ST_IDLE && cnt_q == 10'(CNT_MAX)) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_IDLE;
            cnt_d      = '0;
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (sync_ok) begin
                        sync_valid_d = 1'b1;
                        nib_cnt_d    = '0;
                        nibble_idx_d = '0;
                        state_d      = ST_NIBBLES;
                    end
                end
                ST_NIBBLES: begin
                    if (nib_ok) begin
                        nibble_valid_d = 1'b1;
                        nibble_data_d  = period[3:0] - 4'(NIBBLE_BASE);
                        nibble_idx_d   = nib_cnt_q;
                        nib_cnt_d      = nib_cnt_q + 4'd1;
                        if (nib_cnt_q == CRC_IDX) begin
                            frame_done_d = 1'b1;
                            state_d      = optional_pause ? ST_PAUSE : ST_WAIT_SYNC;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NIBBLE;
                        state_d    = ST_HUNT;
                    end
                end
                ST_PAUSE: begin
                    if (pause_ok) begin
                        state_d = ST_WAIT_SYNC;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_PAUSE;
                        state_d    = ST_HUNT;
                    end
                end
                ST_WAIT_SYNC: begin
                    if (sync_ok) begin
                        sync_valid_d = 1'b1;
                        nib_cnt_d    = '0;
                        nibble_idx_d = '0;
                        state_d      = ST_NIBBLES;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_SYNC;
                        state_d    = ST_HUNT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            nib_cnt_q      <= '0;
            nibble_valid_q <= 1'b0;
            nibble_data_q  <= '0;
            nibble_idx_q   <= '0;
            sync_valid_q   <= 1'b0;
            frame_done_q   <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            nib_cnt_q      <= nib_cnt_d;
            nibble_valid_q <= nibble_valid_d;
            nibble_data_q  <= nibble_data_d;
            nibble_idx_q   <= nibble_idx_d;
            sync_valid_q   <= sync_valid_d;
            frame_done_q   <= frame_done_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
        end
    end

    assign nibble_valid = nibble_valid_q;
    assign nibble_data  = nibble_data_q;
    assign nibble_idx   = nibble_idx_q;
    assign sync_valid   = sync_valid_q;
    assign frame_done   = frame_done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_sent_rx_pulse_decode.sv
// Table-driven bench: each row is one SENT period plus the strobe expected on its opening edge.
module tb_sent_rx_pulse_decode;
    import sent_pkg::*;

    logic       clk = 1'b0;
    logic       reset, ticks = 1'b0, enable, optional_pause, data_pulse;
    logic       nibble_valid, sync_valid, frame_done, err;
    logic [3:0] nibble_data, nibble_idx;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;
    int excl_viol = 0;

    sent_rx_pulse_decode #(.NUM_DATA(6), .SYNC_TOL(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .ticks          (ticks),
        .enable         (enable),
        .optional_pause (optional_pause),
        .data_pulse     (data_pulse),
        .nibble_valid   (nibble_valid),
        .nibble_data    (nibble_data),
        .nibble_idx     (nibble_idx),
        .sync_valid     (sync_valid),
        .frame_done     (frame_done),
        .err            (err),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    // One tick every two clocks.
    initial forever begin
        @(negedge clk);
        ticks = ~ticks;
    end

    typedef enum logic [2:0] {EV_NONE, EV_SYNC, EV_NIB, EV_ERR, EV_STRAY} ev_e;
    typedef struct {
        ev_e        kind;
        logic [3:0] data;
        logic [3:0] idx;
        logic       fd;
        logic [1:0] code;
    } ev_t;
    typedef struct {
        int         p;
        logic       op;
        ev_e        kind;
        logic [3:0] data;
        logic [3:0] idx;
        logic       fd;
        logic [1:0] code;
    } vec_t;

    ev_t  evq[$];
    vec_t vecs[$];
    int   nibs[8] = '{5, 1, 2, 3, 4, 5, 6, 9};

    always @(negedge clk) begin
        if (!reset) begin
            if (int'(sync_valid) + int'(nibble_valid) + int'(err) > 1) excl_viol++;
            if (sync_valid)
                evq.push_back('{kind: EV_SYNC, data: 4'd0, idx: 4'd0, fd: 1'b0, code: 2'd0});
            if (nibble_valid)
                evq.push_back('{kind: EV_NIB, data: nibble_data, idx: nibble_idx, fd: frame_done, code: 2'd0});
            else if (frame_done)
                evq.push_back('{kind: EV_STRAY, data: 4'd0, idx: 4'd0, fd: 1'b1, code: 2'd0});
            if (err)
                evq.push_back('{kind: EV_ERR, data: 4'd0, idx: 4'd0, fd: 1'b0, code: err_code});
        end
    end

    function automatic void add(int p, logic op, ev_e k, int d = 0, int i = 0, int fd = 0, int c = 0);
        vecs.push_back('{p: p, op: op, kind: k, data: 4'(d), idx: 4'(i), fd: 1'(fd), code: 2'(c)});
    endfunction

    // Sync period, status nibble and nibbles 0..6; the caller adds the row that closes the CRC.
    function automatic void add_frame(ev_e k0, int c0);
        add(56, 1'b0, k0, 0, 0, 0, c0);
        add(12 + nibs[0], 1'b0, EV_SYNC);
        for (int i = 0; i < 7; i++)
            add(12 + nibs[i+1], 1'b0, EV_NIB, nibs[i], i);
    endfunction

    task automatic wait_ticks(input int n);
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic pulse(input int p);
        data_pulse = 1'b0;
        wait_ticks(4);
        data_pulse = 1'b1;
        wait_ticks(p - 4);
    endtask

    task automatic check_ev(input string name, input ev_e k, input int d, input int i,
                            input int fd, input int c);
        ev_t got, exp;
        exp = '{kind: k, data: 4'(d), idx: 4'(i), fd: 1'(fd), code: 2'(c)};
        checks++;
        if (k == EV_NONE) begin
            if (evq.size() != 0) begin
                errors++;
                $display("FAIL %s: got %0d strobe event(s), first kind=%0d, required none",
                         name, evq.size(), evq[0].kind);
                evq.delete();
            end
        end else if (evq.size() == 0) begin
            errors++;
            $display("FAIL %s: got no strobe, required kind=%0d data=%0d idx=%0d fd=%0d code=%0d",
                     name, k, d, i, fd, c);
        end else begin
            got = evq.pop_front();
            if (got.kind != exp.kind || got.data !== exp.data || got.idx !== exp.idx ||
                got.fd !== exp.fd || got.code !== exp.code) begin
                errors++;
                $display("FAIL %s: got kind=%0d data=%0d idx=%0d fd=%0d code=%0d, required kind=%0d data=%0d idx=%0d fd=%0d code=%0d",
                         name, got.kind, got.data, got.idx, got.fd, got.code,
                         exp.kind, exp.data, exp.idx, exp.fd, exp.code);
            end
        end
    endtask

    task automatic do_reset();
        data_pulse = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({nibble_valid, nibble_data, nibble_idx, sync_valid, frame_done, err, err_code} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got nv=%0d nd=%0d ni=%0d sv=%0d fd=%0d err=%0d code=%0d, required all 0",
                     nibble_valid, nibble_data, nibble_idx, sync_valid, frame_done, err, err_code);
        end
    endtask

    task automatic run_range(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            if (vecs[i].p == 0) begin
                do_reset();
            end else begin
                optional_pause = vecs[i].op;
                pulse(vecs[i].p);
                check_ev($sformatf("vec%0d", i), vecs[i].kind, int'(vecs[i].data),
                         int'(vecs[i].idx), int'(vecs[i].fd), int'(vecs[i].code));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        optional_pause = 1'b0;
        data_pulse = 1'b1;

        // Case 1: plain frame, next sync closes the CRC (rows 0..11)
        add(0, 1'b0, EV_NONE);
        add_frame(EV_NONE, 0);
        add(56, 1'b0, EV_NIB, 9, 7, 1);
        add(20, 1'b0, EV_SYNC);
        // Case 2: 100-tick pause then a 57-tick sync
        add(0, 1'b0, EV_NONE);
        add_frame(EV_NONE, 0);
        add(100, 1'b1, EV_NIB, 9, 7, 1);
        add(57, 1'b0, EV_NONE);
        add(20, 1'b0, EV_SYNC);
        // Case 3: over-long nibble, then a 55-tick sync from HUNT
        add(0, 1'b0, EV_NONE);
        add(56, 1'b0, EV_NONE);
        add(30, 1'b0, EV_SYNC);
        add(55, 1'b0, EV_ERR, 0, 0, 0, 0);
        add(20, 1'b0, EV_SYNC);
        // Case 4: bad sync after CRC, then an 800-tick pause
        add(0, 1'b0, EV_NONE);
        add_frame(EV_NONE, 0);
        add(40, 1'b0, EV_NIB, 9, 7, 1);
        add(20, 1'b0, EV_ERR, 0, 0, 0, 1);
        add_frame(EV_NONE, 0);
        add(800, 1'b1, EV_NIB, 9, 7, 1);
        add(20, 1'b0, EV_ERR, 0, 0, 0, 2);
        add(0, 1'b0, EV_NONE);

        run_range(0, vecs.size() - 1);

        // Case 5: line stuck high after a sync
        do_reset();
        pulse(56);
        check_ev("to_start", EV_NONE, 0, 0, 0, 0);
        pulse(1100);
        check_ev("to_sync", EV_SYNC, 0, 0, 0, 0);
        check_ev("to_err", EV_ERR, 0, 0, 0, 3);
        checks++;
        if (dut.state_q != ST_IDLE) begin
            errors++;
            $display("FAIL to_state: got state=%0d, required %0d", dut.state_q, ST_IDLE);
        end

        // Case 6a: reset in the middle of the frame, then a clean frame
        run_range(0, 6);
        wait_ticks(8);
        do_reset();
        wait_ticks(200);
        check_ev("rst_quiet", EV_NONE, 0, 0, 0, 0);
        run_range(1, 11);

        // Case 6b: enable dropped mid-frame while the line keeps toggling
        run_range(0, 6);
        enable = 1'b0;
        pulse(17);
        pulse(18);
        pulse(21);
        pulse(56);
        pulse(20);
        check_ev("en_quiet", EV_NONE, 0, 0, 0, 0);
        enable = 1'b1;
        wait_ticks(10);
        run_range(1, 11);

        checks++;
        if (excl_viol != 0) begin
            errors++;
            $display("FAIL strobe_excl: got %0d overlapping cycles, required 0", excl_viol);
        end
        check_ev("tail_empty", EV_NONE, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
